// File: rtl/mpsoc_ram_1r1w_fifo_ctrl.sv
// mpsoc_ram_1r1w_fifo_ctrl: valid/ready FIFO controller for a 1R1W RAM with a 2-entry output buffer.
// Defining MPSOC_FIFO_FLUSH_EN adds flush_i, a synchronous clear that leaves the RAM contents intact.
module mpsoc_ram_1r1w_fifo_ctrl #(
    parameter int ABITS = 10,
    parameter int DBITS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef MPSOC_FIFO_FLUSH_EN
    input  logic                   flush_i,
`endif
    input  logic                   push_valid_i,
    input  logic [DBITS-1:0]       push_data_i,
    output logic                   push_ready_o,
    output logic                   pop_valid_o,
    output logic [DBITS-1:0]       pop_data_o,
    input  logic                   pop_ready_i,
    output logic [ABITS+1:0]       level_o,
    output logic [ABITS-1:0]       ram_waddr_o,
    output logic [DBITS-1:0]       ram_din_o,
    output logic                   ram_we_o,
    output logic [(DBITS+7)/8-1:0] ram_be_o,
    output logic [ABITS-1:0]       ram_raddr_o,
    output logic                   ram_re_o,
    input  logic [DBITS-1:0]       ram_dout_i
);
    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};
    logic             clr;
    logic [ABITS-1:0] wptr, rptr;
    logic [ABITS:0]   ram_cnt;
    logic             inflight;
    logic [DBITS-1:0] ob0, ob1, ob0_nxt, ob1_nxt;
    logic [1:0]       ob_cnt, ob_base, ob_cnt_nxt;
    logic [2:0]       ob_need;
    logic             push_fire, pop_fire;
`ifdef MPSOC_FIFO_FLUSH_EN
    assign clr = rst_i | flush_i;
`else
    assign clr = rst_i;
`endif
    assign push_ready_o = ~clr & (ram_cnt < DEPTH);
    assign push_fire    = push_valid_i & push_ready_o;
    assign pop_valid_o  = ~rst_i & (ob_cnt != 2'd0);
    assign pop_fire     = pop_valid_o & pop_ready_i;
    assign pop_data_o   = ob0;
    assign ram_we_o     = push_fire;
    assign ram_waddr_o  = wptr;
    assign ram_din_o    = push_data_i;
    assign ram_be_o     = '1;
    assign ram_raddr_o  = rptr;
    // Only issue a read if the buffer can absorb its data next cycle after this cycle's pop.
    assign ob_need  = 3'(ob_cnt) + 3'(inflight) - 3'(pop_fire);
    assign ram_re_o = ~clr & ((ram_cnt != '0) | push_fire) & (ob_need < 3'd2);
    assign level_o  = rst_i ? '0 : (ABITS+2)'(ram_cnt) + (ABITS+2)'(inflight) + (ABITS+2)'(ob_cnt);
    assign ob_base    = ob_cnt - 2'(pop_fire);
    assign ob_cnt_nxt = ob_base + 2'(inflight);
    assign ob0_nxt    = (inflight && ob_base == 2'd0) ? ram_dout_i : pop_fire ? ob1 : ob0;
    assign ob1_nxt    = (inflight && ob_base != 2'd0) ? ram_dout_i : ob1;
    always_ff @(posedge clk_i) begin
        if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
        end else begin
            wptr     <= wptr + ABITS'(push_fire);
            rptr     <= rptr + ABITS'(ram_re_o);
            ram_cnt  <= ram_cnt + (ABITS+1)'(push_fire) - (ABITS+1)'(ram_re_o);
            inflight <= ram_re_o;
            ob_cnt   <= ob_cnt_nxt;
        end
    end
    always_ff @(posedge clk_i) begin
        ob0 <= ob0_nxt;
        ob1 <= ob1_nxt;
    end
endmodule

// File: tb/tb_mpsoc_ram_1r1w_fifo_ctrl.sv
// tb_mpsoc_ram_1r1w_fifo_ctrl: randomized and directed bench against a queue model of the FIFO.
module tb_mpsoc_ram_1r1w_fifo_ctrl;
    localparam int AB = 2;
    localparam int DB = 32;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic push_valid = 1'b0, pop_ready = 1'b0;
    logic [DB-1:0] push_data = '0;
    logic push_ready_o, pop_valid_o, ram_we_o, ram_re_o;
    logic [DB-1:0] pop_data_o, ram_din_o, ram_dout;
    logic [AB+1:0] level_o;
    logic [AB-1:0] ram_waddr_o, ram_raddr_o;
    logic [3:0] ram_be_o;
    logic [DB-1:0] mem [2**AB];

    mpsoc_ram_1r1w_fifo_ctrl #(.ABITS(AB), .DBITS(DB)) dut (
        .clk_i(clk), .rst_i(rst),
`ifdef MPSOC_FIFO_FLUSH_EN
        .flush_i(flush),
`endif
        .push_valid_i(push_valid), .push_data_i(push_data), .push_ready_o(push_ready_o),
        .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o), .pop_ready_i(pop_ready),
        .level_o(level_o), .ram_waddr_o(ram_waddr_o), .ram_din_o(ram_din_o),
        .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_raddr_o(ram_raddr_o),
        .ram_re_o(ram_re_o), .ram_dout_i(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 1R1W RAM: registered read, write-first on address collision.
    always @(posedge clk) begin
        if (ram_we_o) mem[ram_waddr_o] <= ram_din_o;
        if (ram_re_o) ram_dout <= (ram_we_o && ram_waddr_o == ram_raddr_o) ? ram_din_o : mem[ram_raddr_o];
    end

    int checks = 0, errors = 0;
    int pops = 0, max_level = 0;
    logic [DB-1:0] q[$];
    logic [DB-1:0] last_pop, prev_data, s_data;
    logic s_valid, s_ready, s_we, s_re, prev_stall = 1'b0;
    logic [AB+1:0] s_level;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample outputs mid-cycle, check against the model, advance the model.
    task automatic tick();
        logic pf, qf;
        #2;
        s_valid = pop_valid_o; s_ready = push_ready_o; s_we = ram_we_o; s_re = ram_re_o;
        s_data = pop_data_o; s_level = level_o;
        pf = push_valid & push_ready_o;
        qf = pop_valid_o & pop_ready;
        if (rst) begin
            check("rst_valid", pop_valid_o, 0);
            check("rst_level", level_o, 0);
            check("rst_ready", push_ready_o, 0);
            check("rst_we", ram_we_o, 0);
            check("rst_re", ram_re_o, 0);
        end else begin
            check("level", level_o, q.size());
            if (q.size() == 0) check("empty_valid", pop_valid_o, 0);
            if (q.size() == 0 && !pf) check("empty_re", ram_re_o, 0);
            if (pop_valid_o && q.size() != 0) check("head", pop_data_o, q[0]);
            if (pf) check("ram_din", ram_din_o, push_data);
            if (prev_stall) begin
                check("stall_valid", pop_valid_o, 1);
                check("stall_data", pop_data_o, prev_data);
            end
        end
        if (int'(level_o) > max_level) max_level = int'(level_o);
        prev_stall = pop_valid_o & ~pop_ready & ~rst & ~flush;
        prev_data = pop_data_o;
        if (qf) begin
            last_pop = pop_data_o;
            pops++;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (pf) q.push_back(push_data);
        if (rst || flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        push_valid = 1'b0;
        pop_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);
        tick();
    endtask

    task automatic clear_test(input logic use_flush);
        int p;
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1; push_data = 32'h700 + i; tick();
        end
        push_valid = 1'b0;
        tick(); tick();
        check("held3_level", s_level, 3);
        if (use_flush) flush = 1'b1; else rst = 1'b1;
        tick();
        flush = 1'b0; rst = 1'b0;
        tick();
        check("clr_valid", s_valid, 0);
        check("clr_level", s_level, 0);
        check("clr_ready", s_ready, 1);
        p = pops;
        push_valid = 1'b1; push_data = 32'h55; pop_ready = 1'b1;
        tick();
        push_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("clr_pops", pops - p, 1);
        check("clr_data", last_pop, 32'h55);
    endtask

    initial begin
        int nxt, cyc, bubbles, acc, p;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        check("be_ones", ram_be_o, 4'hF);
        rst = 1'b0;

        // Single push latency
        push_valid = 1'b1; push_data = 32'hA5A5_0001; pop_ready = 1'b1;
        tick();
        check("lat_ready", s_ready, 1);
        check("lat_we", s_we, 1);
        push_valid = 1'b0;
        tick();
        check("lat_c1_valid", s_valid, 0);
        tick();
        check("lat_c2_valid", s_valid, 1);
        check("lat_c2_data", s_data, 32'hA5A5_0001);
        tick();
        check("lat_c3_level", s_level, 0);

        // Full-rate stream
        nxt = 0; cyc = 0; bubbles = 0; max_level = 0;
        while (nxt < 1024 && cyc < 3000) begin
            push_valid = 1'b1; push_data = nxt; p = pops;
            tick();
            if (s_ready) nxt++;
            if (cyc >= 2 && pops == p) bubbles++;
            cyc++;
        end
        check("stream_cnt", nxt, 1024);
        check("stream_cycles", cyc, 1024);
        check("stream_bubbles", bubbles, 0);
        check("stream_maxlvl", max_level <= 3, 1);
        drain();

        // Fill to full with pop stalled
        pop_ready = 1'b0; acc = 0;
        for (int i = 1; i <= 8; i++) begin
            push_valid = 1'b1; push_data = i;
            tick();
            if (s_ready) acc++;
        end
        push_valid = 1'b0;
        tick();
        check("full_acc", acc, 6);
        check("full_ready", s_ready, 0);
        check("full_level", s_level, 6);
        push_valid = 1'b1; push_data = 32'h99; pop_ready = 1'b1; p = pops;
        tick();
        check("full_pop_push_blocked", s_ready, 0);
        check("full_pop_re", s_re, 1);
        push_valid = 1'b0;
        tick();
        check("full_reopen", s_ready, 1);
        drain();
        check("full_pops", pops - p, 6);
        check("full_last", last_pop, 6);

        // Toggling pop_ready under continuous push
        nxt = 0;
        for (int i = 0; i < 80; i++) begin
            push_valid = 1'b1; push_data = 32'h1000 + nxt; pop_ready = i[0];
            tick();
            if (s_ready) nxt++;
        end
        drain();

        // Random traffic, wraps the small RAM many times
        push_data = $urandom;
        for (int i = 0; i < 600; i++) begin
            push_valid = ($urandom_range(0, 3) != 0);
            pop_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (s_ready || !push_valid) push_data = $urandom;
        end
        drain();

        clear_test(1'b0);
        drain();
`ifdef MPSOC_FIFO_FLUSH_EN
        clear_test(1'b1);
        drain();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
